pe_ifmap_rx: RTL
================

PE_IFMAP_RX -- requirements
Module: pe_ifmap_rx

Interface
REQ-001 Parameter NODE_ID, default 1: 4-bit value this node matches against packet dest field [51:48].
REQ-002 Parameter ROWS_EXP, default 1: number of valid rows expected per load, legal range 1..25.
REQ-003 Parameter FIFO_DEPTH, default 4: row buffer entries, power of two, minimum 2.
REQ-004 clk  in  1  single clock; all state is updated on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that arms a new load.
REQ-007 pkt_valid  in  1  router offers a packet.
REQ-008 pkt_ready  out  1  block accepts a packet; a transfer occurs when pkt_valid and pkt_ready are both high on a clock edge.
REQ-009 pkt_data  in  57  packet: [56] ifmap flag, [55:52] source, [51:48] dest, [47:40] routing, [24:0] row payload.
REQ-010 row_valid  out  1  buffered row available to the PE.
REQ-011 row_ready  in  1  PE consumes a row; a pop occurs when row_valid and row_ready are both high.
REQ-012 row_data  out  25  payload bits [24:0] of the head row.
REQ-013 row_src  out  4  source field of the head row.
REQ-014 row_idx  out  5  arrival index of the head row, starting at 0.
REQ-015 busy  out  1  high in RECV or DRAIN.
REQ-016 done  out  1  level, high in DONE.
REQ-017 err  out  1  one-cycle pulse when a packet is dropped.

Function
REQ-018 FSM states: IDLE, RECV, DRAIN, DONE.
- IDLE->RECV on start.
- RECV->DRAIN when the ROWS_EXP-th valid packet is accepted.
- DRAIN->DONE when the FIFO is empty.
- DONE->RECV on start.
REQ-019 pkt_ready is high only in RECV with the FIFO not full; pkt_ready is registered-state based and does not depend on row_ready.
REQ-020 A packet is valid if pkt_data[56]==1 and pkt_data[51:48]==NODE_ID; a valid packet pushes {src, payload, idx} and increments the 5-bit row counter.
REQ-021 An invalid accepted packet is discarded, is not counted, and pulses err in the following cycle.
REQ-022 Latency: a pushed row appears on row_valid/row_data one cycle after acceptance; there is no same-cycle bypass.
REQ-023 Simultaneous push and pop: both occur, and occupancy is unchanged.
REQ-024 When full, pkt_ready is 0 even if a pop occurs in that cycle.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; occupancy is tracked with one extra bit so that full and empty are distinct.
REQ-026 row_idx equals the counter value at push time; the counter clears on each start.
REQ-027 start in RECV or DRAIN is ignored.
REQ-028 Routing bits [47:40] and bits [39:25] are ignored.

Reset
REQ-029 When rst is high at a clock edge, the block enters IDLE and clears the FIFO, pointers, and row counter.
REQ-030 Output values while in reset: pkt_ready=0, row_valid=0, row_data=0, row_src=0, row_idx=0, busy=0, done=0, err=0.
REQ-031 Reset applied mid-load discards all buffered rows; a new start is required after reset.

Configuration
REQ-032 Macro PE_IFMAP_RX_DROP_CNT_EN, defined: adds output drop_cnt (8 bits), which increments on each err, saturates at 255, and clears on rst and on start.
REQ-033 Macro PE_IFMAP_RX_DROP_CNT_EN, undefined: the drop_cnt port and its counter do not exist; all other behaviour is identical.

Verification
REQ-034 NODE_ID=1, ROWS_EXP=1: start, then one packet with [56]=1, dest=1, src=12, payload 0x1ABCDEF, row_ready=1 -> next cycle row_valid=1, row_data=0x1ABCDEF, row_src=12, row_idx=0; done=1 two cycles after acceptance.
REQ-035 NODE_ID=5, ROWS_EXP=21: 21 valid packets with payloads 4..24 -> row_idx 0..20 delivered in order; done only after the last pop.
REQ-036 row_ready=0, FIFO_DEPTH=4: after 4 accepted packets pkt_ready=0; one pop -> pkt_ready returns high the next cycle, and no row is lost or duplicated.
REQ-037 Packet with dest=3 at NODE_ID=1, then a packet with [56]=0 -> both accepted, err pulses twice, row counter stays 0, and drop_cnt=2 when the macro is enabled.
REQ-038 rst asserted while 3 rows are buffered in RECV -> next cycle row_valid=0, busy=0, state IDLE; a packet with pkt_valid=1 is not accepted until start.
REQ-039 start pulses in RECV and DONE -> ignored in RECV, restarts in DONE with row_idx beginning at 0.

Source files
------------

// File: rtl/pe_ifmap_rx.sv
// pe_ifmap_rx: receives ifmap row packets addressed to this node, buffers them in a small FIFO
// and hands them to the PE. Optional drop counter is enabled by PE_IFMAP_RX_DROP_CNT_EN.
module pe_ifmap_rx #(
   parameter int unsigned NODE_ID    = 1,
   parameter int unsigned ROWS_EXP   = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        pkt_valid,
   output logic        pkt_ready,
   input  logic [56:0] pkt_data,
   output logic        row_valid,
   input  logic        row_ready,
   output logic [24:0] row_data,
   output logic [3:0]  row_src,
   output logic [4:0]  row_idx,
   output logic        busy,
   output logic        done,
   output logic        err
`ifdef PE_IFMAP_RX_DROP_CNT_EN
   ,
   output logic [7:0]  drop_cnt
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned EW = 34;  // {src[3:0], payload[24:0], idx[4:0]}

   typedef enum logic [1:0] {StIdle, StRecv, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            err_q, err_d;
   logic [EW-1:0]   mem_q [FIFO_DEPTH];
   logic [EW-1:0]   mem_d [FIFO_DEPTH];

   logic            empty, full, pkt_ok, accept, push, pop, last_row, arm;
   logic [EW-1:0]   head;
   logic            unused_pkt_bits;

   // Routing and spare bits carry nothing for this block.
   assign unused_pkt_bits = ^pkt_data[47:25];

   // FIFO status, handshakes and packet classification.
   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pkt_ready = (state_q == StRecv) && !full;
      row_valid = !empty;
      pkt_ok    = pkt_data[56] && (pkt_data[51:48] == 4'(NODE_ID));
      accept    = pkt_valid && pkt_ready;
      push      = accept && pkt_ok;
      pop       = row_valid && row_ready;
      last_row  = (cnt_q == 5'(ROWS_EXP - 1));
      arm       = start && ((state_q == StIdle) || (state_q == StDone));
   end

   // Next-state: FIFO pointers/storage, row counter, drop pulse and load FSM.
   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      mem_d    = mem_q;
      err_d    = accept && !pkt_ok;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = {pkt_data[55:52], pkt_data[24:0], cnt_q};
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
         cnt_d                   = cnt_q + 5'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
      unique case (state_q)
         StIdle, StDone: begin
            if (arm) begin
               state_d = StRecv;
               cnt_d   = '0;
            end
         end
         StRecv: begin
            if (push && last_row) state_d = StDrain;
         end
         // Leave as soon as the final pop empties the buffer.
         StDrain: begin
            if (rd_ptr_d == wr_ptr_d) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         mem_q    <= '{default: '0};
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         mem_q    <= mem_d;
      end
   end

   // Head-of-FIFO outputs, forced to zero while nothing is buffered.
   always_comb begin
      head     = mem_q[rd_ptr_q[AW-1:0]];
      row_src  = row_valid ? head[33:30] : '0;
      row_data = row_valid ? head[29:5]  : '0;
      row_idx  = row_valid ? head[4:0]   : '0;
      busy     = (state_q == StRecv) || (state_q == StDrain);
      done     = (state_q == StDone);
      err      = err_q;
   end

`ifdef PE_IFMAP_RX_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   // Saturating count of dropped packets, cleared when a load is armed.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (arm) begin
         drop_cnt_d = '0;
      end else if (err_q && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   // Drop counter register.
   always_ff @(posedge clk) begin
      if (rst) drop_cnt_q <= '0;
      else     drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule
